// File: rtl/sel_encode_unit.sv
// Instruction-latching register select/encode unit: holds the IR, decodes Ra/Rb/Rc into
// one-hot register-file enables, and runs a built-in Rb->Rc->Ra transfer sequencer.
module sel_encode_unit #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int OPCODE_W = 5,
   parameter int RA_LSB   = 23,
   parameter int RB_LSB   = 19,
   parameter int RC_LSB   = 15,
   parameter int IMM_W    = 19
) (
   input  logic                          clock,
   input  logic                          clear_n,
   input  logic                          ir_load,
   input  logic [DATA_W-1:0]             instruction,
   input  logic                          gra,
   input  logic                          grb,
   input  logic                          grc,
   input  logic                          rin,
   input  logic                          rout,
   input  logic                          ba_out,
   input  logic                          seq_start,
   input  logic                          seq_stall,
   output logic [OPCODE_W-1:0]           opcode,
   output logic [DATA_W-1:0]             c_sign_ext,
   output logic [$clog2(NUM_REGS)-1:0]   sel_index,
   output logic [NUM_REGS-1:0]           reg_in,
   output logic [NUM_REGS-1:0]           reg_out,
   output logic                          zero_out,
   output logic                          seq_busy,
   output logic                          seq_done
);

   localparam int SEL_W = $clog2(NUM_REGS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_B,
      S_RD_C,
      S_WR_A,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_ir;

   logic [SEL_W-1:0]    w_ra;
   logic [SEL_W-1:0]    w_rb;
   logic [SEL_W-1:0]    w_rc;
   logic [SEL_W-1:0]    w_sel;
   logic                w_en_in;
   logic                w_en_out;
   logic                w_zero;
   logic                w_busy;
   logic                w_done;
   logic [NUM_REGS-1:0] w_onehot;

   assign w_ra = r_ir[RA_LSB +: SEL_W];
   assign w_rb = r_ir[RB_LSB +: SEL_W];
   assign w_rc = r_ir[RC_LSB +: SEL_W];

   // The IR only accepts a new word while the sequencer is idle, so a running
   // transfer always sees a stable set of register fields.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_ir    <= '0;
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
         if (ir_load && (r_state == S_IDLE)) begin
            r_ir <= instruction;
         end
      end
   end

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_sel       = '0;
      w_en_in     = 1'b0;
      w_en_out    = 1'b0;
      w_zero      = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (seq_start) begin
               w_state_nxt = S_RD_B;
            end
            // Manual mode: strict priority, a single field only.
            if (gra || grb || grc) begin
               if (gra) begin
                  w_sel = w_ra;
               end else if (grb) begin
                  w_sel = w_rb;
               end else begin
                  w_sel = w_rc;
               end
               w_en_in  = rin;
               w_en_out = rout | ba_out;
               // Base-address read of R0 means a literal zero, not the register.
               if (ba_out && !rout && (w_sel == '0)) begin
                  w_en_out = 1'b0;
                  w_zero   = 1'b1;
               end
            end
         end
         S_RD_B: begin
            w_busy   = 1'b1;
            w_sel    = w_rb;
            w_en_out = 1'b1;
            if (!seq_stall) begin
               w_state_nxt = S_RD_C;
            end
         end
         S_RD_C: begin
            w_busy   = 1'b1;
            w_sel    = w_rc;
            w_en_out = 1'b1;
            if (!seq_stall) begin
               w_state_nxt = S_WR_A;
            end
         end
         S_WR_A: begin
            w_busy  = 1'b1;
            w_sel   = w_ra;
            w_en_in = 1'b1;
            if (!seq_stall) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_sel;

   assign opcode     = r_ir[DATA_W-1 -: OPCODE_W];
   assign c_sign_ext = {{(DATA_W-IMM_W){r_ir[IMM_W-1]}}, r_ir[IMM_W-1:0]};
   assign sel_index  = w_sel;
   assign reg_in     = w_onehot & {NUM_REGS{w_en_in}};
   assign reg_out    = w_onehot & {NUM_REGS{w_en_out}};
   assign zero_out   = w_zero;
   assign seq_busy   = w_busy;
   assign seq_done   = w_done;

endmodule

// File: tb/tb_sel_encode_unit.sv
// Scoreboard bench for sel_encode_unit: expectations are queued as stimulus is driven and
// compared at the following falling edge; a 32-register build is checked separately.
module tb_sel_encode_unit;

   logic        clock = 1'b0;
   logic        clear_n;
   logic        ir_load, gra, grb, grc, rin, rout, ba_out, seq_start, seq_stall;
   logic [31:0] instruction;
   logic [4:0]  opcode;
   logic [31:0] c_sign_ext;
   logic [3:0]  sel_index;
   logic [15:0] reg_in, reg_out;
   logic        zero_out, seq_busy, seq_done;

   // 32-register build with fields re-placed so 5-bit selects fit below the opcode.
   logic        p_ir_load, p_gra, p_rin;
   logic [31:0] p_instruction;
   logic [4:0]  p_opcode;
   logic [31:0] p_c_sign_ext;
   logic [4:0]  p_sel_index;
   logic [31:0] p_reg_in, p_reg_out;
   logic        p_zero_out, p_seq_busy, p_seq_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   sel_encode_unit dut (
      .clock(clock), .clear_n(clear_n), .ir_load(ir_load), .instruction(instruction),
      .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .ba_out(ba_out),
      .seq_start(seq_start), .seq_stall(seq_stall),
      .opcode(opcode), .c_sign_ext(c_sign_ext), .sel_index(sel_index),
      .reg_in(reg_in), .reg_out(reg_out), .zero_out(zero_out),
      .seq_busy(seq_busy), .seq_done(seq_done)
   );

   sel_encode_unit #(
      .NUM_REGS(32), .RA_LSB(22), .RB_LSB(17), .RC_LSB(12), .IMM_W(12)
   ) dut32 (
      .clock(clock), .clear_n(clear_n), .ir_load(p_ir_load), .instruction(p_instruction),
      .gra(p_gra), .grb(1'b0), .grc(1'b0), .rin(p_rin), .rout(1'b0), .ba_out(1'b0),
      .seq_start(1'b0), .seq_stall(1'b0),
      .opcode(p_opcode), .c_sign_ext(p_c_sign_ext), .sel_index(p_sel_index),
      .reg_in(p_reg_in), .reg_out(p_reg_out), .zero_out(p_zero_out),
      .seq_busy(p_seq_busy), .seq_done(p_seq_done)
   );

   typedef struct {
      string       tag;
      bit          chk_sel;
      logic [3:0]  sel;
      logic [15:0] rin;
      logic [15:0] rout;
      logic        zero;
      logic        busy;
      logic        done;
      logic [4:0]  op;
      logic [31:0] cse;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_ir;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference field layout for the default build.
   function automatic logic [31:0] m_sext(input logic [31:0] ir);
      return {{13{ir[18]}}, ir[18:0]};
   endfunction

   function automatic logic [15:0] m_bit(input int n);
      logic [15:0] v;
      v = '0;
      v[n] = 1'b1;
      return v;
   endfunction

   task automatic push_exp(input string tag, input bit chk_sel, input logic [3:0] sel,
                           input logic [15:0] rin_e, input logic [15:0] rout_e,
                           input logic zero, input logic busy, input logic done);
      exp_t e;
      e.tag = tag; e.chk_sel = chk_sel; e.sel = sel; e.rin = rin_e; e.rout = rout_e;
      e.zero = zero; e.busy = busy; e.done = done;
      e.op  = m_ir[31:27];
      e.cse = m_sext(m_ir);
      sb_q.push_back(e);
   endtask

   task automatic sample();
      exp_t e;
      if (sb_q.size() == 0) begin
         check("scoreboard_empty", 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      if (e.chk_sel) check({e.tag, "_sel"}, 64'(sel_index), 64'(e.sel));
      check({e.tag, "_reg_in"},   64'(reg_in),     64'(e.rin));
      check({e.tag, "_reg_out"},  64'(reg_out),    64'(e.rout));
      check({e.tag, "_zero_out"}, 64'(zero_out),   64'(e.zero));
      check({e.tag, "_busy"},     64'(seq_busy),   64'(e.busy));
      check({e.tag, "_done"},     64'(seq_done),   64'(e.done));
      check({e.tag, "_opcode"},   64'(opcode),     64'(e.op));
      check({e.tag, "_cse"},      64'(c_sign_ext), 64'(e.cse));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic manual_idle();
      {gra, grb, grc, rin, rout, ba_out, seq_start, seq_stall, ir_load} = '0;
   endtask

   task automatic load_ir(input logic [31:0] v);
      instruction = v;
      ir_load     = 1'b1;
      tick();
      ir_load = 1'b0;
      m_ir    = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_n = 1'b0;
      manual_idle();
      instruction = '0;
      {p_ir_load, p_gra, p_rin} = '0;
      p_instruction = '0;
      m_ir = '0;

      #3;
      push_exp("reset", 1, 4'd0, 16'h0, 16'h0, 0, 0, 0);
      sample();
      @(negedge clock);
      #2 clear_n = 1'b1;

      // Decode: Ra=3 Rb=4 Rc=8, imm field bit 18 is Rc's MSB so it sign-extends.
      load_ir(32'h09A4_0005);
      grb = 1; rout = 1;
      push_exp("decode_rb", 1, 4'd4, 16'h0, m_bit(4), 0, 0, 0);
      @(negedge clock); sample();
      manual_idle();

      load_ir(32'h0004_0000);
      push_exp("imm_neg", 1, 4'd0, 16'h0, 16'h0, 0, 0, 0);
      @(negedge clock); sample();

      load_ir(32'h1000_0005);
      push_exp("imm_pos", 1, 4'd0, 16'h0, 16'h0, 0, 0, 0);
      @(negedge clock); sample();

      // Priority: all selects set, only Ra is driven.
      load_ir(32'h09A4_0005);
      gra = 1; grb = 1; grc = 1; rin = 1;
      push_exp("prio_all", 1, 4'd3, m_bit(3), 16'h0, 0, 0, 0);
      @(negedge clock); sample();
      tick();
      gra = 0;
      push_exp("prio_bc", 1, 4'd4, m_bit(4), 16'h0, 0, 0, 0);
      @(negedge clock); sample();
      tick();
      grb = 0; grc = 0; rout = 1;
      push_exp("no_select", 1, 4'd0, 16'h0, 16'h0, 0, 0, 0);
      @(negedge clock); sample();
      manual_idle();

      // R0 base-address read versus ordinary read.
      load_ir(32'h0980_0005);
      grb = 1; ba_out = 1;
      push_exp("r0_base", 1, 4'd0, 16'h0, 16'h0, 1, 0, 0);
      @(negedge clock); sample();
      tick();
      ba_out = 0; rout = 1;
      push_exp("r0_rout", 1, 4'd0, 16'h0, m_bit(0), 0, 0, 0);
      @(negedge clock); sample();
      tick();
      grb = 0; rout = 0; gra = 1; ba_out = 1;
      push_exp("ra_base", 1, 4'd3, 16'h0, m_bit(3), 0, 0, 0);
      @(negedge clock); sample();
      manual_idle();

      // Sequence started on the same edge as an IR load; one stall in RD_C.
      tick();
      instruction = 32'h09A4_0005; ir_load = 1; seq_start = 1;
      tick();
      m_ir = 32'h09A4_0005;
      instruction = 32'hFFFF_FFFF;   // load attempted while busy
      gra = 1; rin = 1; rout = 1;
      push_exp("seq_rd_b", 1, 4'd4, 16'h0, m_bit(4), 0, 1, 0);
      @(negedge clock); sample();
      tick();
      ir_load = 0; seq_stall = 1;
      push_exp("seq_rd_c", 1, 4'd8, 16'h0, m_bit(8), 0, 1, 0);
      @(negedge clock); sample();
      tick();
      seq_stall = 0;
      push_exp("seq_rd_c_stall", 1, 4'd8, 16'h0, m_bit(8), 0, 1, 0);
      @(negedge clock); sample();
      tick();
      push_exp("seq_wr_a", 1, 4'd3, m_bit(3), 16'h0, 0, 1, 0);
      @(negedge clock); sample();
      tick();
      push_exp("seq_done", 0, 4'd0, 16'h0, 16'h0, 0, 1, 1);
      @(negedge clock); sample();
      tick();
      seq_start = 0;
      push_exp("seq_idle_manual", 1, 4'd3, m_bit(3), m_bit(3), 0, 0, 0);
      @(negedge clock); sample();
      manual_idle();

      // Asynchronous reset in the middle of RD_C.
      tick();
      seq_start = 1;
      tick();
      seq_start = 0;
      push_exp("rst_rd_b", 1, 4'd4, 16'h0, m_bit(4), 0, 1, 0);
      @(negedge clock); sample();
      tick();
      push_exp("rst_rd_c", 1, 4'd8, 16'h0, m_bit(8), 0, 1, 0);
      @(negedge clock); sample();
      #1 clear_n = 1'b0;
      #1;
      m_ir = '0;
      push_exp("rst_mid_seq", 1, 4'd0, 16'h0, 16'h0, 0, 0, 0);
      sample();
      @(negedge clock);
      #2 clear_n = 1'b1;
      tick();
      push_exp("rst_after1", 1, 4'd0, 16'h0, 16'h0, 0, 0, 0);
      @(negedge clock); sample();
      tick();
      push_exp("rst_after2", 1, 4'd0, 16'h0, 16'h0, 0, 0, 0);
      @(negedge clock); sample();

      // 32-register build: Ra=31 at bits 26:22.
      p_instruction = 32'h07C0_0000;
      p_ir_load = 1;
      tick();
      p_ir_load = 0; p_gra = 1; p_rin = 1;
      @(negedge clock);
      check("p32_reg_in",  64'(p_reg_in),    64'h8000_0000);
      check("p32_sel",     64'(p_sel_index), 64'd31);
      check("p32_reg_out", 64'(p_reg_out),   64'd0);
      check("sb_drained",  64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
